pc_predict_unit: RTL and testbench

Parametrised IF-stage program-counter unit with a direct-mapped branch target buffer (BTB). It holds the fetch PC and selects the next PC each cycle from trap redirect, execute-stage redirect, stall hold, BTB prediction or sequential increment. It also exposes the prediction so EX can detect mispredicts, and keeps a saturating redirect counter for performance monitoring. It sits between the hazard unit/EX stage and instruction memory.

---
 rtl/pc_predict_unit_if.sv | 33 +++
 rtl/pc_predict_unit.sv | 106 ++++++++++
 tb/tb_pc_predict_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pc_predict_unit_if.sv
// Signal bundle between the hazard unit / EX stage (master) and the IF-stage
// PC predictor (slave).
interface pc_predict_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              wr_en;
    logic              trap_valid;
    logic [ADDR_W-1:0] trap_addr;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              btb_upd_valid;
    logic [ADDR_W-1:0] btb_upd_pc;
    logic              btb_upd_taken;
    logic [ADDR_W-1:0] btb_upd_target;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [CNT_W-1:0]  redirect_cnt;

    modport master (
        output wr_en, trap_valid, trap_addr, redirect_valid, redirect_addr,
               btb_upd_valid, btb_upd_pc, btb_upd_taken, btb_upd_target,
        input  pc_out, pc_plus, pred_taken, pred_target, redirect_cnt
    );

    modport slave (
        input  wr_en, trap_valid, trap_addr, redirect_valid, redirect_addr,
               btb_upd_valid, btb_upd_pc, btb_upd_taken, btb_upd_target,
        output pc_out, pc_plus, pred_taken, pred_target, redirect_cnt
    );
endinterface

// File: rtl/pc_predict_unit.sv
// IF-stage fetch PC register with a direct-mapped BTB and a saturating
// redirect counter. Bus interface widths must match ADDR_W / CNT_W.
module pc_predict_unit #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = {ADDR_W{1'b0}},
    parameter int                INST_BYTES  = 4,
    parameter int                BTB_ENTRIES = 8,
    parameter int                CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    pc_predict_unit_if.slave  bus
);
    localparam int OFS_W = $clog2(INST_BYTES);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - OFS_W;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] addr);
        return addr & ~(ADDR_W'(INST_BYTES) - ADDR_W'(1));
    endfunction

    logic [ADDR_W-1:0]      pc_out_r;
    logic [CNT_W-1:0]       redirect_cnt_r;
    logic [BTB_ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]       tag_r    [BTB_ENTRIES];
    logic [ADDR_W-1:0]      target_r [BTB_ENTRIES];

    logic [IDX_W-1:0]  lkp_idx_s;
    logic              hit_s;
    logic [ADDR_W-1:0] pc_plus_s;
    logic [ADDR_W-1:0] pred_target_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic [IDX_W-1:0]  upd_idx_s;
    logic [TAG_W-1:0]  upd_tag_s;
    logic              unused_s;

    // Low offset bits of the update PC never reach the index or tag.
    assign unused_s = ^bus.btb_upd_pc;

    // BTB lookup for the current fetch PC and next-PC selection.
    always_comb begin
        lkp_idx_s     = pc_out_r[OFS_W +: IDX_W];
        hit_s         = valid_r[lkp_idx_s] &&
                        (tag_r[lkp_idx_s] == pc_out_r[ADDR_W-1 -: TAG_W]);
        pc_plus_s     = pc_out_r + ADDR_W'(INST_BYTES);
        pred_target_s = pc_plus_s;
        if (hit_s) begin
            pred_target_s = target_r[lkp_idx_s];
        end else begin
            pred_target_s = pc_plus_s;
        end

        next_pc_s = pc_out_r;
        if (bus.trap_valid) begin
            next_pc_s = align(bus.trap_addr);
        end else if (bus.redirect_valid) begin
            next_pc_s = align(bus.redirect_addr);
        end else if (!bus.wr_en) begin
            next_pc_s = pc_out_r;
        end else begin
            next_pc_s = pred_target_s;
        end

        upd_idx_s = bus.btb_upd_pc[OFS_W +: IDX_W];
        upd_tag_s = bus.btb_upd_pc[ADDR_W-1 -: TAG_W];
    end

    // Fetch PC register and saturating redirect counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out_r       <= RESET_VEC;
            redirect_cnt_r <= {CNT_W{1'b0}};
        end else begin
            pc_out_r <= next_pc_s;
            if ((bus.trap_valid || bus.redirect_valid) &&
                (redirect_cnt_r != {CNT_W{1'b1}})) begin
                redirect_cnt_r <= redirect_cnt_r + CNT_W'(1);
            end
        end
    end

    // BTB training from resolved branches; a not-taken outcome only evicts its own tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {BTB_ENTRIES{1'b0}};
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {ADDR_W{1'b0}};
            end
        end else if (bus.btb_upd_valid) begin
            if (bus.btb_upd_taken) begin
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= align(bus.btb_upd_target);
            end else if (valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s)) begin
                valid_r[upd_idx_s] <= 1'b0;
            end
        end
    end

    assign bus.pc_out       = pc_out_r;
    assign bus.pc_plus      = pc_plus_s;
    assign bus.pred_taken   = hit_s;
    assign bus.pred_target  = pred_target_s;
    assign bus.redirect_cnt = redirect_cnt_r;
endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed test of pc_predict_unit: sequential fetch, stall, redirect priority,
// BTB train/evict/alias, wrap-around and counter saturation (second instance).
module tb_pc_predict_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pc_predict_unit_if #(.ADDR_W(32), .CNT_W(16)) bus0 ();
    pc_predict_unit_if #(.ADDR_W(32), .CNT_W(2))  bus1 ();

    pc_predict_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .INST_BYTES(4),
                      .BTB_ENTRIES(8), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    pc_predict_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .INST_BYTES(4),
                      .BTB_ENTRIES(8), .CNT_W(2))  u1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus0.trap_valid = 1'b0;  bus0.trap_addr = 32'h0;
        bus0.redirect_valid = 1'b0; bus0.redirect_addr = 32'h0;
        bus0.btb_upd_valid = 1'b0; bus0.btb_upd_pc = 32'h0;
        bus0.btb_upd_taken = 1'b0; bus0.btb_upd_target = 32'h0;
        bus0.wr_en = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        bus0.redirect_valid = 1'b1; bus0.redirect_addr = a;
        step();
        bus0.redirect_valid = 1'b0;
    endtask

    task automatic btb_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bus0.btb_upd_valid = 1'b1; bus0.btb_upd_pc = pc;
        bus0.btb_upd_taken = tk;   bus0.btb_upd_target = tgt;
        step();
        bus0.btb_upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        clear_req();
        bus1.wr_en = 1'b1; bus1.trap_valid = 1'b0; bus1.trap_addr = 32'h0;
        bus1.redirect_valid = 1'b0; bus1.redirect_addr = 32'h0;
        bus1.btb_upd_valid = 1'b0; bus1.btb_upd_pc = 32'h0;
        bus1.btb_upd_taken = 1'b0; bus1.btb_upd_target = 32'h0;
        rst = 1'b1;
        step(); step();
        total++; if (bus0.pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", bus0.pc_out, 32'h0); end
        total++; if (bus0.pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken got=%b exp=0", bus0.pred_taken); end
        total++; if (bus0.pred_target !== 32'h4) begin bad++; $display("FAIL reset_pred_target got=%h exp=%h", bus0.pred_target, 32'h4); end
        total++; if (bus0.redirect_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus0.redirect_cnt); end
        rst = 1'b0;
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc = exp_pc + 32'h4;
            total++; if (bus0.pc_out !== exp_pc) begin bad++; $display("FAIL seq_pc got=%h exp=%h", bus0.pc_out, exp_pc); end
            total++; if (bus0.pred_taken !== 1'b0) begin bad++; $display("FAIL seq_pred_taken got=%b exp=0", bus0.pred_taken); end
        end
    endtask

    task automatic test_stall_redirect();
        step();
        total++; if (bus0.pc_out !== 32'h10) begin bad++; $display("FAIL pre_stall_pc got=%h exp=%h", bus0.pc_out, 32'h10); end
        bus0.wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus0.pc_out !== 32'h10) begin bad++; $display("FAIL stall_pc got=%h exp=%h", bus0.pc_out, 32'h10); end
        end
        redirect_to(32'h200);
        total++; if (bus0.pc_out !== 32'h200) begin bad++; $display("FAIL stall_redirect_pc got=%h exp=%h", bus0.pc_out, 32'h200); end
        total++; if (bus0.redirect_cnt !== 16'd1) begin bad++; $display("FAIL stall_redirect_cnt got=%0d exp=1", bus0.redirect_cnt); end
        bus0.wr_en = 1'b1;
    endtask

    task automatic test_priority();
        bus0.trap_valid = 1'b1; bus0.trap_addr = 32'h80;
        bus0.redirect_valid = 1'b1; bus0.redirect_addr = 32'h300;
        step();
        bus0.trap_valid = 1'b0; bus0.redirect_valid = 1'b0;
        total++; if (bus0.pc_out !== 32'h80) begin bad++; $display("FAIL trap_prio_pc got=%h exp=%h", bus0.pc_out, 32'h80); end
        total++; if (bus0.redirect_cnt !== 16'd2) begin bad++; $display("FAIL trap_prio_cnt got=%0d exp=2", bus0.redirect_cnt); end
        redirect_to(32'h103);
        total++; if (bus0.pc_out !== 32'h100) begin bad++; $display("FAIL align_pc got=%h exp=%h", bus0.pc_out, 32'h100); end
        total++; if (bus0.redirect_cnt !== 16'd3) begin bad++; $display("FAIL align_cnt got=%0d exp=3", bus0.redirect_cnt); end
    endtask

    task automatic test_btb_train();
        btb_update(32'h20, 1'b1, 32'h400);
        total++; if (bus0.pc_out !== 32'h104) begin bad++; $display("FAIL train_seq_pc got=%h exp=%h", bus0.pc_out, 32'h104); end
        redirect_to(32'h20);
        total++; if (bus0.pred_taken !== 1'b1) begin bad++; $display("FAIL hit_taken got=%b exp=1", bus0.pred_taken); end
        total++; if (bus0.pred_target !== 32'h400) begin bad++; $display("FAIL hit_target got=%h exp=%h", bus0.pred_target, 32'h400); end
        step();
        total++; if (bus0.pc_out !== 32'h400) begin bad++; $display("FAIL hit_next_pc got=%h exp=%h", bus0.pc_out, 32'h400); end
        btb_update(32'h20, 1'b0, 32'h0);
        total++; if (bus0.pc_out !== 32'h404) begin bad++; $display("FAIL evict_seq_pc got=%h exp=%h", bus0.pc_out, 32'h404); end
        redirect_to(32'h20);
        total++; if (bus0.pred_taken !== 1'b0) begin bad++; $display("FAIL evict_taken got=%b exp=0", bus0.pred_taken); end
        total++; if (bus0.pred_target !== 32'h24) begin bad++; $display("FAIL evict_target got=%h exp=%h", bus0.pred_target, 32'h24); end
        step();
        total++; if (bus0.pc_out !== 32'h24) begin bad++; $display("FAIL evict_next_pc got=%h exp=%h", bus0.pc_out, 32'h24); end
        total++; if (bus0.redirect_cnt !== 16'd5) begin bad++; $display("FAIL btb_cnt got=%0d exp=5", bus0.redirect_cnt); end
    endtask

    task automatic test_alias();
        btb_update(32'h20, 1'b1, 32'h400);
        btb_update(32'h40, 1'b1, 32'h503);
        redirect_to(32'h20);
        total++; if (bus0.pred_taken !== 1'b0) begin bad++; $display("FAIL alias_taken got=%b exp=0", bus0.pred_taken); end
        step();
        total++; if (bus0.pc_out !== 32'h24) begin bad++; $display("FAIL alias_next_pc got=%h exp=%h", bus0.pc_out, 32'h24); end
        redirect_to(32'h40);
        total++; if (bus0.pred_taken !== 1'b1) begin bad++; $display("FAIL replace_taken got=%b exp=1", bus0.pred_taken); end
        total++; if (bus0.pred_target !== 32'h500) begin bad++; $display("FAIL replace_target got=%h exp=%h", bus0.pred_target, 32'h500); end
        bus0.wr_en = 1'b0;
        btb_update(32'h60, 1'b0, 32'h0);
        bus0.wr_en = 1'b1;
        total++; if (bus0.pc_out !== 32'h40) begin bad++; $display("FAIL mismatch_stall_pc got=%h exp=%h", bus0.pc_out, 32'h40); end
        total++; if (bus0.pred_taken !== 1'b1) begin bad++; $display("FAIL mismatch_keep_taken got=%b exp=1", bus0.pred_taken); end
        step();
        total++; if (bus0.pc_out !== 32'h500) begin bad++; $display("FAIL mismatch_next_pc got=%h exp=%h", bus0.pc_out, 32'h500); end
        redirect_to(32'h80);
        btb_update(32'h80, 1'b1, 32'h600);
        total++; if (bus0.pc_out !== 32'h84) begin bad++; $display("FAIL no_bypass_pc got=%h exp=%h", bus0.pc_out, 32'h84); end
        total++; if (bus0.redirect_cnt !== 16'd8) begin bad++; $display("FAIL alias_cnt got=%0d exp=8", bus0.redirect_cnt); end
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        total++; if (bus0.pc_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", bus0.pc_out, 32'hFFFF_FFFC); end
        total++; if (bus0.pc_plus !== 32'h0) begin bad++; $display("FAIL wrap_pc_plus got=%h exp=%h", bus0.pc_plus, 32'h0); end
        total++; if (bus0.pred_target !== 32'h0) begin bad++; $display("FAIL wrap_pred_target got=%h exp=%h", bus0.pred_target, 32'h0); end
        step();
        total++; if (bus0.pc_out !== 32'h0) begin bad++; $display("FAIL wrap_next_pc got=%h exp=%h", bus0.pc_out, 32'h0); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt;
        exp_cnt = 2'd0;
        total++; if (bus1.redirect_cnt !== 2'd0) begin bad++; $display("FAIL sat_start got=%0d exp=0", bus1.redirect_cnt); end
        for (int i = 0; i < 5; i++) begin
            bus1.redirect_valid = 1'b1; bus1.redirect_addr = 32'h1000;
            bus1.trap_valid = (i == 4); bus1.trap_addr = 32'h2000;
            step();
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            total++; if (bus1.redirect_cnt !== exp_cnt) begin bad++; $display("FAIL sat_cnt got=%0d exp=%0d", bus1.redirect_cnt, exp_cnt); end
        end
        bus1.redirect_valid = 1'b0; bus1.trap_valid = 1'b0;
        total++; if (bus1.pc_out !== 32'h2000) begin bad++; $display("FAIL sat_trap_pc got=%h exp=%h", bus1.pc_out, 32'h2000); end
    endtask

    task automatic test_reset_midway();
        bus0.btb_upd_valid = 1'b1; bus0.btb_upd_pc = 32'h8;
        bus0.btb_upd_taken = 1'b1; bus0.btb_upd_target = 32'h700;
        #2 rst = 1'b1;
        #1;
        total++; if (bus0.pc_out !== 32'h0 || bus0.redirect_cnt !== 16'd0) begin bad++; $display("FAIL async_reset got pc=%h cnt=%0d exp pc=0 cnt=0", bus0.pc_out, bus0.redirect_cnt); end
        step();
        clear_req();
        rst = 1'b0;
        redirect_to(32'h8);
        total++; if (bus0.pred_taken !== 1'b0) begin bad++; $display("FAIL reset_drops_upd got=%b exp=0", bus0.pred_taken); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stall_redirect();
        test_priority();
        test_btb_train();
        test_alias();
        test_wrap();
        test_saturate();
        test_reset_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
